// File: rtl/bit_serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding and
// the bit-counter width rule.
package bit_serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // A one-bit adder still needs a one-bit counter.
    function automatic int cnt_width(input int width);
        if (width <= 1) begin
            return 1;
        end else begin
            return $clog2(width);
        end
    endfunction

endpackage

// File: rtl/bit_serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The master drives operands and accepts results; the slave is the adder.
interface bit_serial_adder_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_out;
    logic             c_out;
    logic             busy;

    modport master (
        output in_valid, a_in, b_in, c_in, out_ready,
        input  in_ready, out_valid, sum_out, c_out, busy
    );

    modport slave (
        input  in_valid, a_in, b_in, c_in, out_ready,
        output in_ready, out_valid, sum_out, c_out, busy
    );
endinterface

// File: rtl/bit_serial_adder_fa.sv
// Single full-adder cell; the only arithmetic element on the serial datapath.
module bit_serial_adder_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, fed one
// LSB-first bit pair per clock between an input and an output handshake.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    bit_serial_adder_if.slave     bus
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q, carry_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             out_valid_q, out_valid_d;
    logic             fa_s_s, fa_c_s;
    logic             accept_s, last_bit_s;

    bit_serial_adder_fa u_fa (
        .a_i (a_sr_q[0]),
        .b_i (b_sr_q[0]),
        .c_i (carry_q),
        .s_o (fa_s_s),
        .c_o (fa_c_s)
    );

    assign accept_s   = bus.in_valid & in_ready_q;
    assign last_bit_s = (cnt_q == CW'(WIDTH - 1));

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            sum_sr_q    <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            sum_sr_q    <= sum_sr_d;
            carry_q     <= carry_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_bit_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand load and one-bit-per-clock shift through the full adder.
    always_comb begin
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    a_sr_d   = bus.a_in;
                    b_sr_d   = bus.b_in;
                    carry_d  = bus.c_in;
                    cnt_d    = '0;
                    sum_sr_d = '0;
                end else begin
                    cnt_d    = cnt_q;
                end
            end
            ST_SHIFT: begin
                // New sum bit enters at the MSB so the LSB-first stream lands in place.
                sum_sr_d = WIDTH'({fa_s_s, sum_sr_q} >> 1);
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                carry_d  = fa_c_s;
                cnt_d    = cnt_q + CW'(1);
            end
            ST_DONE: begin
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Handshake outputs decoded from the next state so they flop alongside it.
    always_comb begin
        in_ready_d  = (state_d == ST_IDLE);
        busy_d      = (state_d == ST_SHIFT);
        out_valid_d = (state_d == ST_DONE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum_out   = sum_sr_q;
    assign bus.c_out     = carry_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and random checks of bit_serial_adder at WIDTH=8 and WIDTH=1.
module tb_bit_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;

    bit_serial_adder_if #(.WIDTH(8)) bus8 ();
    bit_serial_adder_if #(.WIDTH(1)) bus1 ();

    bit_serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    bit_serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Launch one add on the 8-bit DUT and wait for the result (no release).
    task automatic do_add(input logic [7:0] a, input logic [7:0] b, input logic c,
                          output logic [7:0] s, output logic co,
                          output int lat, output int bcnt);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus8.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 32'd0, 32'd1);
        bus8.a_in = a; bus8.b_in = b; bus8.c_in = c; bus8.in_valid = 1'b1;
        lat = 0; bcnt = 0;
        while (lat < 50) begin
            @(negedge clk);
            bus8.in_valid = 1'b0;
            lat++;
            if (bus8.busy) bcnt++;
            if (bus8.out_valid) break;
        end
        if (lat >= 50) check("out_valid_timeout", 32'd0, 32'd1);
        s = bus8.sum_out; co = bus8.c_out;
    endtask

    task automatic release_out();
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.out_ready = 1'b0;
        check("ov_drop", 32'(bus8.out_valid), 32'd0);
        check("ir_back", 32'(bus8.in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] s, ra, rb;
        logic       co, rc;
        logic [8:0] ref_sum;
        int         lat, bcnt, seen;

        bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
        bus8.a_in = 8'h00; bus8.b_in = 8'h00; bus8.c_in = 1'b0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
        bus1.a_in = 1'b0; bus1.b_in = 1'b0; bus1.c_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 32'(bus8.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        check("rst_busy", 32'(bus8.busy), 32'd0);
        check("rst_sum", 32'(bus8.sum_out), 32'd0);
        check("rst_c_out", 32'(bus8.c_out), 32'd0);
        check("rst_w1_in_ready", 32'(bus1.in_ready), 32'd1);

        // 1: basic add, latency and busy length
        do_add(8'h5A, 8'h33, 1'b0, s, co, lat, bcnt);
        check("t1_sum", 32'(s), 32'h8D);
        check("t1_cout", 32'(co), 32'd0);
        check("t1_latency", 32'(lat), 32'd9);
        check("t1_busy_cycles", 32'(bcnt), 32'd8);
        release_out();

        // 2: carry propagation corners
        do_add(8'hFF, 8'h01, 1'b0, s, co, lat, bcnt);
        check("t2a_sum", 32'(s), 32'h00);
        check("t2a_cout", 32'(co), 32'd1);
        release_out();
        do_add(8'hFF, 8'hFF, 1'b1, s, co, lat, bcnt);
        check("t2b_sum", 32'(s), 32'hFF);
        check("t2b_cout", 32'(co), 32'd1);
        release_out();

        // 3: back-pressure for 20 cycles
        do_add(8'hA5, 8'h5A, 1'b1, s, co, lat, bcnt);
        check("t3_sum", 32'(s), 32'h00);
        check("t3_cout", 32'(co), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(bus8.out_valid), 32'd1);
            check("t3_hold_sum", 32'(bus8.sum_out), 32'h00);
            check("t3_hold_cout", 32'(bus8.c_out), 32'd1);
            check("t3_hold_in_ready", 32'(bus8.in_ready), 32'd0);
        end
        release_out();

        // 4: IN_VALID during SHIFT and DONE is ignored
        @(negedge clk);
        bus8.a_in = 8'h12; bus8.b_in = 8'h34; bus8.c_in = 1'b0; bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        @(negedge clk);
        bus8.a_in = 8'hFF; bus8.b_in = 8'hFF; bus8.c_in = 1'b1; bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        seen = 0;
        while (!bus8.out_valid && seen < 50) begin
            @(negedge clk);
            seen++;
        end
        check("t4_valid_seen", 32'(bus8.out_valid), 32'd1);
        check("t4_sum", 32'(bus8.sum_out), 32'h46);
        check("t4_cout", 32'(bus8.c_out), 32'd0);
        bus8.a_in = 8'h01; bus8.b_in = 8'h01; bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        check("t4_done_sum", 32'(bus8.sum_out), 32'h46);
        check("t4_done_in_ready", 32'(bus8.in_ready), 32'd0);
        release_out();
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.out_valid) seen++;
        end
        check("t4_no_second", 32'(seen), 32'd0);

        // 5: reset mid-SHIFT at cnt=4
        @(negedge clk);
        bus8.a_in = 8'hC3; bus8.b_in = 8'h3C; bus8.c_in = 1'b1; bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_busy_before", 32'(bus8.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_in_ready", 32'(bus8.in_ready), 32'd1);
        check("t5_busy", 32'(bus8.busy), 32'd0);
        check("t5_out_valid", 32'(bus8.out_valid), 32'd0);
        check("t5_sum", 32'(bus8.sum_out), 32'd0);
        check("t5_cout", 32'(bus8.c_out), 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.out_valid) seen++;
        end
        check("t5_no_partial", 32'(seen), 32'd0);
        do_add(8'h10, 8'h20, 1'b0, s, co, lat, bcnt);
        check("t5_fresh_sum", 32'(s), 32'h30);
        check("t5_fresh_cout", 32'(co), 32'd0);
        release_out();

        // 6a: WIDTH=1 truth table
        for (int v = 0; v < 8; v++) begin
            int e;
            e = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
            @(negedge clk);
            bus1.a_in = 1'((v >> 2) & 1); bus1.b_in = 1'((v >> 1) & 1);
            bus1.c_in = 1'(v & 1); bus1.in_valid = 1'b1;
            @(negedge clk);
            bus1.in_valid = 1'b0;
            check("w1_busy", 32'(bus1.busy), 32'd1);
            check("w1_not_yet", 32'(bus1.out_valid), 32'd0);
            @(negedge clk);
            check("w1_valid", 32'(bus1.out_valid), 32'd1);
            check("w1_result", 32'({bus1.c_out, bus1.sum_out}), 32'(e));
            bus1.out_ready = 1'b1;
            @(negedge clk);
            bus1.out_ready = 1'b0;
            check("w1_drop", 32'(bus1.out_valid), 32'd0);
        end

        // 6b: random vectors against a 9-bit reference sum
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            ref_sum = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            do_add(ra, rb, rc, s, co, lat, bcnt);
            check("rand_result", 32'({co, s}), 32'(ref_sum));
            check("rand_latency", 32'(lat), 32'd9);
            release_out();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
